// File: rtl/timer_mmio_if.sv
// Data-memory bus between the CPU (master) and a memory-mapped responder (slave).
// Carries the same signal set as the ram port so a timer can sit on the same decode.
interface timer_mmio_if;
  logic        chip_enable;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        write_enable;
  logic [31:0] write_address;
  logic [3:0]  write_select;
  logic [31:0] write_data;

  modport master (
    output chip_enable, read_enable, read_address,
    output write_enable, write_address, write_select, write_data,
    input  read_data
  );

  modport slave (
    input  chip_enable, read_enable, read_address,
    input  write_enable, write_address, write_select, write_data,
    output read_data
  );
endinterface

// File: rtl/timer_mmio.sv
// Memory-mapped timer: prescaled up-counter with compare match, one-shot or
// auto-reload, level interrupt, byte-lane writes and zero-latency reads.
module timer_mmio #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
  input  logic         clock,
  input  logic         reset,
  timer_mmio_if.slave  bus,
  output logic         irq
);

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_COMPARE  = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  logic                      ctrl_enable;
  logic                      ctrl_auto_reload;
  logic                      ctrl_irq_enable;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [31:0]               compare;
  logic [31:0]               count;
  logic                      status_match;

  logic        wr;
  logic [2:0]  waddr;
  logic [31:0] wmask;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic        tick, hit;
  logic [31:0] count_hw;
  logic        enable_hw;

  assign wr    = bus.write_enable & bus.chip_enable & (|bus.write_select);
  assign waddr = bus.write_address[4:2];
  assign wmask = {{8{bus.write_select[3]}}, {8{bus.write_select[2]}},
                  {8{bus.write_select[1]}}, {8{bus.write_select[0]}}};

  assign wr_ctrl     = wr & (waddr == ADDR_CTRL);
  assign wr_prescale = wr & (waddr == ADDR_PRESCALE);
  assign wr_compare  = wr & (waddr == ADDR_COMPARE);
  assign wr_count    = wr & (waddr == ADDR_COUNT);
  assign wr_status   = wr & (waddr == ADDR_STATUS);

  assign tick = ctrl_enable & (pre_cnt == prescale);
  assign hit  = (count == compare);

  // Hardware-side next values; byte lanes written by the bus override these.
  always_comb begin
    count_hw  = count;
    enable_hw = ctrl_enable;
    if (tick) begin
      if (!hit) begin
        count_hw = count + 32'd1;
      end else if (ctrl_auto_reload) begin
        count_hw = '0;
      end else begin
        enable_hw = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_enable      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_irq_enable  <= 1'b0;
      prescale         <= '0;
      pre_cnt          <= '0;
      compare          <= RESET_COMPARE;
      count            <= '0;
      status_match     <= 1'b0;
    end else begin
      if (wr_ctrl && bus.write_select[0]) begin
        ctrl_enable      <= bus.write_data[0];
        ctrl_auto_reload <= bus.write_data[1];
        ctrl_irq_enable  <= bus.write_data[2];
      end else begin
        ctrl_enable <= enable_hw;
      end

      if (wr_prescale) begin
        prescale <= (prescale & ~wmask[PRESCALE_WIDTH-1:0]) |
                    (bus.write_data[PRESCALE_WIDTH-1:0] & wmask[PRESCALE_WIDTH-1:0]);
      end

      if (wr_ctrl || wr_prescale) begin
        pre_cnt <= '0;
      end else if (ctrl_enable) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_WIDTH'(1);
      end

      if (wr_compare) begin
        compare <= (compare & ~wmask) | (bus.write_data & wmask);
      end

      if (wr_count) begin
        count <= (count_hw & ~wmask) | (bus.write_data & wmask);
      end else begin
        count <= count_hw;
      end

      // A match set in the same cycle as a W1C takes priority.
      if (tick && hit) begin
        status_match <= 1'b1;
      end else if (wr_status && bus.write_select[0] && bus.write_data[0]) begin
        status_match <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.read_enable && bus.chip_enable) begin
      case (bus.read_address[4:2])
        ADDR_CTRL:     bus.read_data[2:0] = {ctrl_irq_enable, ctrl_auto_reload, ctrl_enable};
        ADDR_PRESCALE: bus.read_data[PRESCALE_WIDTH-1:0] = prescale;
        ADDR_COMPARE:  bus.read_data = compare;
        ADDR_COUNT:    bus.read_data = count;
        ADDR_STATUS:   bus.read_data[0] = status_match;
        default:       bus.read_data = '0;
      endcase
    end
  end

  assign irq = status_match & ctrl_irq_enable;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.read_address[31:5], bus.read_address[1:0],
                              bus.write_address[31:5], bus.write_address[1:0]};

endmodule

// File: tb/tb_timer_mmio.sv
// Bench for timer_mmio: register vector table plus hand-written timing
// sequences; read expectations go through a queue checked at the falling edge.
module tb_timer_mmio;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic irq;

  timer_mmio_if bus();

  timer_mmio #(
    .PRESCALE_WIDTH(16),
    .RESET_COMPARE (32'hFFFF_FFFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .irq  (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  typedef struct {
    bit          we;
    bit          re;
    bit          ce;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (bus.read_data !== mon_e.data || irq !== mon_e.irq) begin
        n_bad++;
        $display("FAIL %s: got read_data=%h irq=%b, want read_data=%h irq=%b",
                 mon_e.name, bus.read_data, irq, mon_e.data, mon_e.irq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic cycle(input bit we, input bit re, input bit ce,
                       input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, input bit chk,
                       input logic [31:0] exp, input logic exp_irq,
                       input string name);
    @(posedge clock);
    #1;
    bus.write_enable  = we;
    bus.read_enable   = re;
    bus.chip_enable   = ce;
    bus.read_address  = addr;
    bus.write_address = addr;
    bus.write_select  = sel;
    bus.write_data    = data;
    if (chk) sb.push_back('{name: name, data: exp, irq: exp_irq});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel = 4'hF);
    cycle(1'b1, 1'b0, 1'b1, addr, sel, data, 1'b0, '0, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_irq, input string name);
    cycle(1'b0, 1'b1, 1'b1, addr, 4'h0, '0, 1'b1, exp, exp_irq, name);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0, '0, 1'b0, "");
  endtask

  initial begin
    bus.chip_enable   = 1'b0;
    bus.read_enable   = 1'b0;
    bus.read_address  = '0;
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.write_select  = '0;
    bus.write_data    = '0;

    tbl.push_back('{0,1,1,32'h00,4'h0,32'h0,1,32'h0000_0000,"rst_ctrl"});
    tbl.push_back('{0,1,1,32'h04,4'h0,32'h0,1,32'h0000_0000,"rst_prescale"});
    tbl.push_back('{0,1,1,32'h08,4'h0,32'h0,1,32'hFFFF_FFFF,"rst_compare"});
    tbl.push_back('{0,1,1,32'h0C,4'h0,32'h0,1,32'h0000_0000,"rst_count"});
    tbl.push_back('{0,1,1,32'h10,4'h0,32'h0,1,32'h0000_0000,"rst_status"});
    tbl.push_back('{0,1,1,32'h14,4'h0,32'h0,1,32'h0000_0000,"rst_off14"});
    tbl.push_back('{0,1,1,32'h18,4'h0,32'h0,1,32'h0000_0000,"rst_off18"});
    tbl.push_back('{0,1,1,32'h1C,4'h0,32'h0,1,32'h0000_0000,"rst_off1c"});
    tbl.push_back('{1,0,0,32'h08,4'hF,32'h0000_1234,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h08,4'h0,32'h0,1,32'hFFFF_FFFF,"ce_gate_wr"});
    tbl.push_back('{0,1,0,32'h08,4'h0,32'h0,1,32'h0000_0000,"ce_gate_rd"});
    tbl.push_back('{0,0,1,32'h08,4'h0,32'h0,1,32'h0000_0000,"re_low_rd"});
    tbl.push_back('{1,1,1,32'h08,4'hF,32'h1234_5678,1,32'hFFFF_FFFF,"rw_same_cycle"});
    tbl.push_back('{0,1,1,32'h0B,4'h0,32'h0,1,32'h1234_5678,"addr_lsb_ignored"});
    tbl.push_back('{0,1,1,32'h28,4'h0,32'h0,1,32'h1234_5678,"addr_msb_ignored"});
    tbl.push_back('{1,0,1,32'h04,4'hF,32'hFFFF_FFFF,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h04,4'h0,32'h0,1,32'h0000_FFFF,"prescale_width"});
    tbl.push_back('{1,0,1,32'h00,4'hF,32'hFFFF_FFF8,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h00,4'h0,32'h0,1,32'h0000_0000,"ctrl_upper_zero"});
    tbl.push_back('{1,0,1,32'h18,4'hF,32'hFFFF_FFFF,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h18,4'h0,32'h0,1,32'h0000_0000,"unused_wr_ignored"});
    tbl.push_back('{1,0,1,32'h0C,4'h0,32'hFFFF_FFFF,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h0C,4'h0,32'h0,1,32'h0000_0000,"sel0_noop"});
    tbl.push_back('{1,0,1,32'h0C,4'h5,32'hAABB_CCDD,0,32'h0,""});
    tbl.push_back('{0,1,1,32'h0C,4'h0,32'h0,1,32'h00BB_00DD,"byte_lanes"});

    // Reset held: state visible immediately, then release.
    cycle(1'b0, 1'b1, 1'b1, 32'h08, 4'h0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0, "in_reset_compare");
    idle();
    @(posedge clock);
    #1 reset = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].ce, tbl[i].addr, tbl[i].sel, tbl[i].data,
            tbl[i].chk, tbl[i].exp, 1'b0, tbl[i].name);
    end

    // Auto-reload: tick every 3 clocks, match after COUNT==3.
    wr(32'h04, 32'd2);
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'h7);
    for (int k = 0; k < 15; k++) begin
      rd(32'h0C, (k < 12) ? 32'(k / 3) : 32'((k - 12) / 3), (k >= 12), "auto_count");
    end
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h0, 1'b0, "auto_clear");

    // One-shot: stops at COUNT==5, no irq without irq_enable.
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd5);
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'h1);
    for (int k = 0; k < 9; k++) begin
      rd(32'h0C, (k < 5) ? 32'(k) : 32'd5, 1'b0, "oneshot_count");
    end
    rd(32'h00, 32'h0, 1'b0, "oneshot_ctrl_stop");
    rd(32'h10, 32'h1, 1'b0, "oneshot_match");
    wr(32'h10, 32'h0);
    rd(32'h10, 32'h1, 1'b0, "status_w0_noeffect");
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h0, 1'b0, "oneshot_w1c");

    // W1C landing on the match tick: set wins.
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd2);
    wr(32'h00, 32'h5);
    idle();
    idle();
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h1, 1'b1, "w1c_collision");
    rd(32'h00, 32'h4, 1'b1, "collision_ctrl");
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h0, 1'b0, "w1c_clear");

    // Wrap without flag, then bus lane write racing a count tick.
    wr(32'h08, 32'd5);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    rd(32'h0C, 32'hFFFF_FFFF, 1'b0, "wrap_pre");
    cycle(1'b1, 1'b1, 1'b1, 32'h0C, 4'b0010, 32'h0000_7700, 1'b1, 32'h0, 1'b0, "wrap_zero");
    rd(32'h0C, 32'h0000_7701, 1'b0, "lane_vs_tick");
    rd(32'h0C, 32'h0000_7702, 1'b0, "lane_vs_tick_next");
    rd(32'h10, 32'h0, 1'b0, "wrap_no_match");
    wr(32'h00, 32'h0);

    // Reset asserted mid-count.
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'h100);
    wr(32'h00, 32'h7);
    idle();
    idle();
    idle();
    rd(32'h0C, 32'd3, 1'b0, "midcount_before_reset");
    cycle(1'b0, 1'b1, 1'b1, 32'h08, 4'h0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0, "async_reset_compare");
    #2 reset = 1'b0;
    idle();
    #1 reset = 1'b1;
    idle();
    rd(32'h0C, 32'd0, 1'b0, "post_reset_count");
    idle();
    rd(32'h0C, 32'd0, 1'b0, "post_reset_hold");
    rd(32'h00, 32'd0, 1'b0, "post_reset_ctrl");

    idle();
    idle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
